flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
Shares the single 21-bit flash read engine between two requesters. Port A is the audio mixer; it is latency-critical and reads one 32-bit word per track per DACLRCK half-period. Port B is a bulk loader, such as image or table fetch. The block sits between both requesters and the flash reader. It issues one non-preemptive read at a time, gives A priority with bounded starvation of B, and recovers from a hung read engine by timeout.

Parameters:
ADDR_W, 21, flash word address width.
DATA_W, 32, read data width.
STARVE_LIMIT, 4, consecutive A grants allowed while B is pending before B is forced.
TIMEOUT, 255, cycles to wait for i_fl_ack before aborting; 8-bit counter.

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_a_req  in  1  A request level; held until o_a_ack or o_a_err
i_a_addr  in  ADDR_W  A read address, sampled at grant
o_a_ack  out  1  one-cycle pulse; o_a_data valid
o_a_err  out  1  one-cycle pulse; A read timed out
o_a_data  out  DATA_W  A read data, held until next A ack
i_b_req  in  1  B request level
i_b_addr  in  ADDR_W  B read address
o_b_ack  out  1  B completion pulse
o_b_err  out  1  B timeout pulse
o_b_data  out  DATA_W  B read data
o_fl_start  out  1  one-cycle start pulse to flash reader
o_fl_addr  out  ADDR_W  address to flash reader, stable from start until ack or abort
i_fl_ack  in  1  flash reader completion pulse
i_fl_data  in  DATA_W  flash reader data, valid with i_fl_ack
o_busy  out  1  transaction outstanding
o_owner  out  1  0 = A, 1 = B; valid while o_busy

Behaviour:
- Clock and reset: one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, starve_cnt 0, timer 0.
- Reset mid-transaction aborts silently; no ack or err is issued afterwards.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is present, latch the owner and address, then go to ISSUE.
  - Owner selection: B if i_b_req and (!i_a_req or starve_cnt == STARVE_LIMIT); otherwise A.
- ISSUE: o_fl_start = 1 for exactly one cycle; o_fl_addr = latched address; timer cleared; go to WAIT.
- WAIT:
  - On i_fl_ack, capture i_fl_data into the owner's data register and go to DONE.
  - Otherwise the timer increments; when timer == TIMEOUT, go to DONE flagged as error.
- DONE: pulse the owner's ack, or err on timeout, for one cycle, then go to IDLE.
- On error, the owner's data register is not updated.
- o_fl_addr holds its value from ISSUE through the end of WAIT.
- o_busy = 1 in ISSUE, WAIT and DONE.
- Latency: request seen in IDLE at cycle N; o_fl_start at N+1; flash ack at cycle M gives owner ack at M+1. The next start is at M+3 at the earliest.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each A grant made while i_b_req is high.
  - Cleared on any B grant, or in IDLE when i_b_req is low.
- A request dropped while its transaction is in flight: the transaction completes and the ack still pulses. Requesters ignore unsolicited acks.
- i_fl_ack arriving in IDLE, ISSUE or DONE is ignored.
- i_fl_ack arriving on the same cycle the timer reaches TIMEOUT: the ack wins and the transaction succeeds.
- Both requests asserted in IDLE with starve_cnt < STARVE_LIMIT: A wins.
- Owner re-requesting in the cycle after its own ack: arbitrated normally in IDLE; no bypass.

Decomposition:
- Shared package flash_arb_pkg:
  - arb_state_t enum: IDLE, ISSUE, WAIT, DONE.
  - OWNER_A = 1'b0 and OWNER_B = 1'b1.
  - Default localparams for ADDR_W and DATA_W.
- One sub-module, arb_starve_ctr: holds the saturating starvation counter and the force_b output.
- Timer and FSM stay in the top module.

Test Plan:
- Single A read, addr 0x00100, flash acks 5 cycles after start with data 0xDEADBEEF -> o_fl_start at N+1 with o_fl_addr 0x00100; o_a_ack at ack+1; o_a_data 0xDEADBEEF; o_b_ack never.
- A and B held continuously, STARVE_LIMIT 4 -> grant order A,A,A,A,B,A,A,A,A,B; o_owner tracks each grant.
- Flash never acks, TIMEOUT 255 -> o_a_err pulses once 256 cycles after start; o_a_data unchanged; o_busy then drops and B is served next.
- i_fl_ack on the same cycle the timer reaches 255 -> ack path taken, err stays 0.
- i_rst asserted in WAIT of a B read, then released; a late i_fl_ack arrives -> outputs 0 during reset; no o_b_ack after release; stray ack ignored in IDLE.
- B alone for 3 reads with 2-cycle flash latency -> start-to-start spacing is exactly 5 cycles; starve_cnt stays 0.

Source files
------------

// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter.
//   arb_state_t : arbiter transaction phases
//   OWNER_A/B   : encoding of the transaction owner (A = audio mixer, B = bulk loader)
//   FL_ADDR_W   : default flash word address width
//   FL_DATA_W   : default flash read data width
package flash_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam int unsigned FL_ADDR_W = 21;
    localparam int unsigned FL_DATA_W = 32;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive A grants made while B is waiting.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   idle     : arbiter is in IDLE this cycle
//   b_req    : B request level
//   grant_a  : A is being granted this cycle
//   grant_b  : B is being granted this cycle
//   force_b  : count has reached LIMIT; the next grant must go to B if it is pending
module arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic b_req,
    input  logic grant_a,
    input  logic grant_b,
    output logic force_b
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        // Grants only happen in IDLE, so an A grant with b_req low is covered by the clear.
        if (grant_b || (idle && !b_req)) begin
            cnt_d = '0;
        end else if (grant_a && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign force_b = (cnt_q == CNT_MAX);

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares one flash read engine between a latency-critical requester A (audio mixer) and a
// bulk requester B. One non-preemptive read at a time; A has priority, but B is forced after
// STARVE_LIMIT consecutive A grants while B waits. A hung read engine is abandoned after
// TIMEOUT wait cycles and the owner receives an error pulse instead of an ack.
// Ports:
//   i_clk, i_rst              : clock, asynchronous active-high reset
//   i_a_req, i_a_addr         : A request level and address (sampled at grant)
//   o_a_ack, o_a_err          : A completion / timeout pulses
//   o_a_data                  : A read data, held until the next A ack
//   i_b_req ... o_b_data      : same for B
//   o_fl_start, o_fl_addr     : start pulse and held address to the flash reader
//   i_fl_ack, i_fl_data       : flash reader completion pulse and data
//   o_busy, o_owner           : transaction outstanding, and whose (0 = A, 1 = B)
module flash_read_arbiter
    import flash_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = FL_ADDR_W,
    parameter int unsigned DATA_W       = FL_DATA_W,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_a_req,
    input  logic [ADDR_W-1:0] i_a_addr,
    output logic              o_a_ack,
    output logic              o_a_err,
    output logic [DATA_W-1:0] o_a_data,
    input  logic              i_b_req,
    input  logic [ADDR_W-1:0] i_b_addr,
    output logic              o_b_ack,
    output logic              o_b_err,
    output logic [DATA_W-1:0] o_b_data,
    output logic              o_fl_start,
    output logic [ADDR_W-1:0] o_fl_addr,
    input  logic              i_fl_ack,
    input  logic [DATA_W-1:0] i_fl_data,
    output logic              o_busy,
    output logic              o_owner
);

    // The timer counts completed wait cycles; the read is abandoned on the cycle the count
    // reaches TIMEOUT, so the error pulse lands TIMEOUT+1 cycles after the start pulse.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        timer_q, timer_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] a_data_q, a_data_d;
    logic [DATA_W-1:0] b_data_q, b_data_d;

    logic in_idle;
    logic grant_a;
    logic grant_b;
    logic force_b;

    assign in_idle = (state_q == IDLE);

    arb_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk    (i_clk),
        .rst    (i_rst),
        .idle   (in_idle),
        .b_req  (i_b_req),
        .grant_a(grant_a),
        .grant_b(grant_b),
        .force_b(force_b)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        timer_d  = timer_q;
        err_d    = err_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        grant_a  = 1'b0;
        grant_b  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_a_req || i_b_req) begin
                    if (i_b_req && (!i_a_req || force_b)) begin
                        owner_d = OWNER_B;
                        addr_d  = i_b_addr;
                        grant_b = 1'b1;
                    end else begin
                        owner_d = OWNER_A;
                        addr_d  = i_a_addr;
                        grant_a = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                err_d   = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                // An ack on the timeout cycle still wins.
                if (i_fl_ack) begin
                    if (owner_q == OWNER_B) begin
                        b_data_d = i_fl_data;
                    end else begin
                        a_data_d = i_fl_data;
                    end
                    state_d = DONE;
                end else begin
                    timer_d = timer_q + 8'd1;
                    if (timer_q == TIMER_LAST) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            owner_q  <= OWNER_A;
            addr_q   <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            a_data_q <= '0;
            b_data_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
        end
    end

    assign o_fl_start = (state_q == ISSUE);
    assign o_fl_addr  = addr_q;
    assign o_busy     = !in_idle;
    assign o_owner    = owner_q;
    assign o_a_ack    = (state_q == DONE) && !err_q && (owner_q == OWNER_A);
    assign o_a_err    = (state_q == DONE) && err_q && (owner_q == OWNER_A);
    assign o_b_ack    = (state_q == DONE) && !err_q && (owner_q == OWNER_B);
    assign o_b_err    = (state_q == DONE) && err_q && (owner_q == OWNER_B);
    assign o_a_data   = a_data_q;
    assign o_b_data   = b_data_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: directed scenarios with literal expectations,
// then randomized requesters and flash responder, all checked every cycle against a
// transaction-level model (grant cycle, start cycle, completion cycle, starvation count).
module tb_flash_read_arbiter;

    localparam int ADDR_W       = 21;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;

    localparam int W_START = 0;
    localparam int W_A_ACK = 1;
    localparam int W_A_ERR = 2;
    localparam int W_B_ACK = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_req, b_req, fl_ack;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] fl_data;
    logic              o_a_ack, o_a_err, o_b_ack, o_b_err, o_fl_start, o_busy, o_owner;
    logic [DATA_W-1:0] o_a_data, o_b_data;
    logic [ADDR_W-1:0] o_fl_addr;

    flash_read_arbiter dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_a_req   (a_req),
        .i_a_addr  (a_addr),
        .o_a_ack   (o_a_ack),
        .o_a_err   (o_a_err),
        .o_a_data  (o_a_data),
        .i_b_req   (b_req),
        .i_b_addr  (b_addr),
        .o_b_ack   (o_b_ack),
        .o_b_err   (o_b_err),
        .o_b_data  (o_b_data),
        .o_fl_start(o_fl_start),
        .o_fl_addr (o_fl_addr),
        .i_fl_ack  (fl_ack),
        .i_fl_data (fl_data),
        .o_busy    (o_busy),
        .o_owner   (o_owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_err = 0;
    int n_chk = 0;

    // Bench-side flash responder / requester configuration.
    int          fl_lat    = 1;   // <= 0: never ack
    int          sched     = -1;
    bit          fl_rand   = 1'b0;
    logic [31:0] fl_val    = 32'h0;
    bit          rand_mode = 1'b0;

    // Observed pulse counts.
    int cnt_a_err = 0;
    int cnt_b_ack = 0;

    // Transaction-level model.
    bit              m_busy = 1'b0;
    bit              m_owner = 1'b0;
    bit              m_err = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    int              m_start = 0;
    int              m_done = -1;
    int              m_starve = 0;
    logic [DATA_W-1:0] m_a_data = '0;
    logic [DATA_W-1:0] m_b_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        bit done_now;
        bit pick_b;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_pulses", 64'({o_a_ack, o_a_err, o_b_ack, o_b_err}), 64'(0));
                check("rst_ctl", 64'({o_fl_start, o_busy, o_owner}), 64'(0));
                check("rst_fl_addr", 64'(o_fl_addr), 64'(0));
                check("rst_a_data", 64'(o_a_data), 64'(0));
                check("rst_b_data", 64'(o_b_data), 64'(0));
                m_busy   = 1'b0;
                m_starve = 0;
                m_a_data = '0;
                m_b_data = '0;
            end else begin
                if (o_a_err) cnt_a_err++;
                if (o_b_ack) cnt_b_ack++;
                done_now = m_busy && (cyc == m_done);
                check("fl_start", 64'(o_fl_start), 64'(m_busy && cyc == m_start));
                check("busy", 64'(o_busy), 64'(m_busy));
                if (m_busy) check("owner", 64'(o_owner), 64'(m_owner));
                if (m_busy && m_done < 0) check("fl_addr", 64'(o_fl_addr), 64'(m_addr));
                check("a_ack", 64'(o_a_ack), 64'(done_now && !m_err && !m_owner));
                check("a_err", 64'(o_a_err), 64'(done_now && m_err && !m_owner));
                check("b_ack", 64'(o_b_ack), 64'(done_now && !m_err && m_owner));
                check("b_err", 64'(o_b_err), 64'(done_now && m_err && m_owner));
                check("a_data", 64'(o_a_data), 64'(m_a_data));
                check("b_data", 64'(o_b_data), 64'(m_b_data));

                // Advance the model with this cycle's inputs.
                if (!m_busy) begin
                    if (a_req || b_req) begin
                        pick_b = b_req && (!a_req || m_starve == STARVE_LIMIT);
                        if (pick_b || !b_req) m_starve = 0;
                        else if (m_starve < STARVE_LIMIT) m_starve++;
                        m_busy  = 1'b1;
                        m_owner = pick_b;
                        m_addr  = pick_b ? b_addr : a_addr;
                        m_start = cyc + 1;
                        m_done  = -1;
                        m_err   = 1'b0;
                    end else begin
                        m_starve = 0;
                    end
                end else if (done_now) begin
                    m_busy = 1'b0;
                end else if (m_done < 0 && cyc > m_start) begin
                    if (fl_ack) begin
                        m_done = cyc + 1;
                        if (m_owner) m_b_data = fl_data;
                        else m_a_data = fl_data;
                    end else if (cyc - m_start == TIMEOUT) begin
                        m_done = cyc + 1;
                        m_err  = 1'b1;
                    end
                end
            end
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic step();
        bit a_fin, b_fin;
        int lat, r;
        a_fin = o_a_ack || o_a_err;
        b_fin = o_b_ack || o_b_err;
        @(posedge clk);
        #1;
        fl_ack = 1'b0;
        if (sched >= 0 && cyc == sched) begin
            fl_ack  = 1'b1;
            fl_data = fl_rand ? $urandom : fl_val;
            sched   = -1;
        end else if (rand_mode && (!o_busy || o_fl_start || o_a_ack || o_a_err || o_b_ack
                                   || o_b_err) && $urandom_range(0, 9) == 0) begin
            fl_ack  = 1'b1;  // stray ack outside WAIT
            fl_data = $urandom;
        end
        if (o_fl_start) begin
            lat = fl_lat;
            if (rand_mode) begin
                r = int'($urandom_range(0, 99));
                if (r == 0) lat = 0;
                else if (r == 1) lat = TIMEOUT;
                else if (r == 2) lat = TIMEOUT - 1;
                else lat = int'($urandom_range(1, 8));
            end
            sched = (lat > 0) ? cyc + lat : -1;
        end
        if (rand_mode) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 799) == 0) rst = 1'b1;
            if (a_fin) begin
                a_req  = ($urandom_range(0, 2) == 0);
                a_addr = ADDR_W'($urandom);
            end else if (!a_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    a_req  = 1'b1;
                    a_addr = ADDR_W'($urandom);
                end
            end else if ($urandom_range(0, 49) == 0) begin
                a_req = 1'b0;
            end
            if (b_fin) begin
                b_req  = ($urandom_range(0, 1) == 0);
                b_addr = ADDR_W'($urandom);
            end else if (!b_req) begin
                if ($urandom_range(0, 4) == 0) begin
                    b_req  = 1'b1;
                    b_addr = ADDR_W'($urandom);
                end
            end else if ($urandom_range(0, 49) == 0) begin
                b_req = 1'b0;
            end
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            W_START: return o_fl_start;
            W_A_ACK: return o_a_ack;
            W_A_ERR: return o_a_err;
            W_B_ACK: return o_b_ack;
            default: return o_b_err;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string name,
                            output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sig(which)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_%s: no event within %0d cycles (cycle %0d)", name, budget, cyc);
        end
    endtask

    initial begin
        int n0, s, s2, s3, d, e, ab;
        logic [9:0] pat;

        rst    = 1'b1;
        a_req  = 1'b0;
        b_req  = 1'b0;
        a_addr = '0;
        b_addr = '0;
        fl_ack = 1'b0;
        fl_data = '0;
        fork
            monitor();
        join_none

        // Reset state.
        step();
        step();
        check("t0_reset_busy", 64'(o_busy), 64'(0));
        check("t0_reset_a_data", 64'(o_a_data), 64'(0));
        rst = 1'b0;
        step();

        // Single A read, flash ack 5 cycles after start.
        fl_lat = 5;
        fl_val = 32'hDEADBEEF;
        a_addr = 21'h00100;
        a_req  = 1'b1;
        n0 = cyc;
        wait_for(W_START, 20, "t1_start", s);
        check("t1_start_cycle", 64'(s), 64'(n0 + 1));
        check("t1_fl_addr", 64'(o_fl_addr), 64'(21'h00100));
        wait_for(W_A_ACK, 20, "t1_ack", d);
        a_req = 1'b0;
        check("t1_ack_cycle", 64'(d), 64'(s + 6));
        check("t1_a_data", 64'(o_a_data), 64'(32'hDEADBEEF));
        for (int i = 0; i < 4; i++) step();
        check("t1_no_b_ack", 64'(cnt_b_ack), 64'(0));

        // A and B held: starvation forces B every fifth grant.
        fl_lat = 1;
        fl_val = 32'h12345678;
        pat    = 10'b1000010000;
        a_addr = 21'h0AAAA;
        b_addr = 21'h15555;
        a_req  = 1'b1;
        b_req  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wait_for(W_START, 20, "t2_start", s);
            check("t2_owner", 64'(o_owner), 64'(pat[i]));
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 8; i++) step();

        // Flash never acks: A times out, then B is served.
        fl_lat = 0;
        a_req  = 1'b1;
        b_req  = 1'b1;
        wait_for(W_START, 20, "t3_start", s);
        check("t3_owner_a", 64'(o_owner), 64'(0));
        wait_for(W_A_ERR, 300, "t3_err", e);
        a_req  = 1'b0;
        fl_lat = 2;
        check("t3_err_delay", 64'(e - s), 64'(256));
        check("t3_a_data_kept", 64'(o_a_data), 64'(32'h12345678));
        step();
        check("t3_busy_drops", 64'(o_busy), 64'(0));
        wait_for(W_START, 5, "t3_b_start", s2);
        check("t3_b_start_cycle", 64'(s2), 64'(e + 2));
        check("t3_owner_b", 64'(o_owner), 64'(1));
        wait_for(W_B_ACK, 10, "t3_b_ack", d);
        b_req = 1'b0;
        check("t3_err_count", 64'(cnt_a_err), 64'(1));

        // Ack on the last wait cycle wins over the timeout.
        fl_lat = TIMEOUT;
        fl_val = 32'hCAFEF00D;
        a_req  = 1'b1;
        wait_for(W_START, 20, "t4_start", s);
        wait_for(W_A_ACK, 300, "t4_ack", d);
        a_req = 1'b0;
        check("t4_ack_cycle", 64'(d), 64'(s + 256));
        check("t4_a_data", 64'(o_a_data), 64'(32'hCAFEF00D));
        check("t4_no_err", 64'(cnt_a_err), 64'(1));
        step();

        // Reset in the middle of a B read; its late flash ack lands in IDLE.
        fl_lat = 10;
        b_addr = 21'h1ABCD;
        b_req  = 1'b1;
        wait_for(W_START, 20, "t5_start", s);
        check("t5_owner_b", 64'(o_owner), 64'(1));
        for (int i = 0; i < 3; i++) step();
        ab    = cnt_b_ack;
        rst   = 1'b1;
        b_req = 1'b0;
        step();
        check("t5_rst_busy", 64'(o_busy), 64'(0));
        check("t5_rst_b_data", 64'(o_b_data), 64'(0));
        step();
        rst = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("t5_no_b_ack", 64'(cnt_b_ack), 64'(ab));
        check("t5_idle", 64'(o_busy), 64'(0));

        // B alone, 2-cycle flash latency: back-to-back starts 5 cycles apart.
        fl_lat = 2;
        b_req  = 1'b1;
        wait_for(W_START, 20, "t6_start1", s);
        wait_for(W_START, 20, "t6_start2", s2);
        wait_for(W_START, 20, "t6_start3", s3);
        b_req = 1'b0;
        check("t6_spacing1", 64'(s2 - s), 64'(5));
        check("t6_spacing2", 64'(s3 - s2), 64'(5));
        check("t6_model_starve", 64'(m_starve), 64'(0));
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic.
        rand_mode = 1'b1;
        fl_rand   = 1'b1;
        for (int i = 0; i < 6000; i++) step();
        rand_mode = 1'b0;
        rst   = 1'b0;
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 300; i++) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
